// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one data-memory port between the core load/store path and a DMA/debug loader.
//   Only one requester is granted per cycle. Read data is registered back to the winner
//   one cycle after its grant. The FSM state records which requester was granted last cycle.
//   Grants are round-robin, except that a locked DMA burst may keep the port for up to
//   MAX_BURST consecutive cycles while the core is waiting.
//
// Optional feature macro: DATA_MEM_ARB_PERF_EN
//   When it is defined, saturating stall and DMA-grant counters drive perf_stall_o and
//   perf_dma_o. When it is undefined, both outputs are constant zero and no counter flops
//   are built.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   core_req_i/we_i/addr_i/wdata_i   core access request
//   core_gnt_o              the core access is performed this cycle
//   core_stall_o            core_req_i & ~core_gnt_o, combinational
//   core_rvalid_o/rdata_o   registered read return for the core
//   dma_req_i/lock_i/we_i/addr_i/wdata_i  DMA access request; lock asks to keep ownership
//   dma_gnt_o               the DMA access is performed this cycle
//   dma_rvalid_o/rdata_o    registered read return for the DMA
//   mem_we_o/addr_o/wd_o    drive to the data memory; all zero when no requester is granted
//   mem_rd_i                combinational read data from the data memory
//   perf_stall_o/perf_dma_o performance counters
module data_mem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // core side
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_gnt_o,
  output logic          core_stall_o,
  output logic          core_rvalid_o,
  output logic [DW-1:0] core_rdata_o,
  // DMA / debug loader side
  input  logic          dma_req_i,
  input  logic          dma_lock_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_gnt_o,
  output logic          dma_rvalid_o,
  output logic [DW-1:0] dma_rdata_o,
  // data memory
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wd_o,
  input  logic [DW-1:0] mem_rd_i,
  // performance counters
  output logic [31:0]   perf_stall_o,
  output logic [31:0]   perf_dma_o
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  typedef logic [BurstW-1:0] burst_t;
  localparam burst_t BurstMax = burst_t'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StCore, StDma} state_e;

  state_e state_q, state_d;
  burst_t burst_q, burst_d;
  logic   core_sel, dma_sel;
  logic   lock_hold;

  logic          core_rvalid_q, dma_rvalid_q;
  logic [DW-1:0] core_rdata_q, dma_rdata_q;

  // A locked DMA burst may keep the port while the core waits, but only until the core has
  // been denied MAX_BURST times in a row.
  assign lock_hold = core_req_i & dma_req_i & dma_lock_i & (burst_q < BurstMax);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the requester that won this cycle, or idle when neither won
  always_comb begin
    state_d = StIdle;
    if (dma_gnt_o) begin
      state_d = StDma;
    end else if (core_gnt_o) begin
      state_d = StCore;
    end
  end

  // Outputs: arbitration, stall and memory mux
  always_comb begin
    core_sel = 1'b0;
    dma_sel  = 1'b0;
    case (state_q)
      StIdle: begin
        if (core_req_i) begin
          core_sel = 1'b1;
        end else if (dma_req_i) begin
          dma_sel = 1'b1;
        end
      end
      StCore: begin
        if (dma_req_i) begin
          dma_sel = 1'b1;
        end else if (core_req_i) begin
          core_sel = 1'b1;
        end
      end
      StDma: begin
        if (lock_hold) begin
          dma_sel = 1'b1;
        end else if (core_req_i) begin
          core_sel = 1'b1;
        end else if (dma_req_i) begin
          dma_sel = 1'b1;
        end
      end
      default: ;
    endcase

    // No grant while reset is asserted, so nothing reaches the memory.
    core_gnt_o   = rst_ni & core_sel;
    dma_gnt_o    = rst_ni & dma_sel;
    core_stall_o = core_req_i & ~core_gnt_o;

    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_wd_o   = '0;
    if (core_gnt_o) begin
      mem_we_o   = core_we_i;
      mem_addr_o = core_addr_i;
      mem_wd_o   = core_wdata_i;
    end else if (dma_gnt_o) begin
      mem_we_o   = dma_we_i;
      mem_addr_o = dma_addr_i;
      mem_wd_o   = dma_wdata_i;
    end
  end

  // The burst count only advances while the core is actually waiting. A core grant or an
  // idle cycle starts a fresh window.
  always_comb begin
    burst_d = burst_q;
    if (core_gnt_o || !dma_gnt_o) begin
      burst_d = '0;
    end else if (core_req_i && (burst_q != BurstMax)) begin
      burst_d = burst_q + burst_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

  // Read return. Each rdata holds its value until the next read by the same requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_rvalid_q <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dma_rdata_q   <= '0;
    end else begin
      core_rvalid_q <= core_gnt_o & ~core_we_i;
      dma_rvalid_q  <= dma_gnt_o & ~dma_we_i;
      if (core_gnt_o && !core_we_i) begin
        core_rdata_q <= mem_rd_i;
      end
      if (dma_gnt_o && !dma_we_i) begin
        dma_rdata_q <= mem_rd_i;
      end
    end
  end

  assign core_rvalid_o = core_rvalid_q;
  assign dma_rvalid_o  = dma_rvalid_q;
  assign core_rdata_o  = core_rdata_q;
  assign dma_rdata_o   = dma_rdata_q;

`ifdef DATA_MEM_ARB_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_dma_q, perf_dma_d;

  // Both counters saturate at all-ones.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_dma_d   = perf_dma_q;
    if (core_stall_o && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (dma_gnt_o && (perf_dma_q != 32'hFFFF_FFFF)) begin
      perf_dma_d = perf_dma_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_dma_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_dma_q   <= perf_dma_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_dma_o   = perf_dma_q;
`else
  assign perf_stall_o = '0;
  assign perf_dma_o   = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter. Expected read data is pushed to a per-requester
// queue in the grant cycle, and it is popped and compared when the matching rvalid must
// appear one cycle later.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        dma_req, dma_lock, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [31:0] perf_stall, perf_dma;

  int tests = 0;
  int failed = 0;
  logic [31:0] core_sb[$];
  logic [31:0] dma_sb[$];

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_gnt_o   (core_gnt),
    .core_stall_o (core_stall),
    .core_rvalid_o(core_rvalid),
    .core_rdata_o (core_rdata),
    .dma_req_i    (dma_req),
    .dma_lock_i   (dma_lock),
    .dma_we_i     (dma_we),
    .dma_addr_i   (dma_addr),
    .dma_wdata_i  (dma_wdata),
    .dma_gnt_o    (dma_gnt),
    .dma_rvalid_o (dma_rvalid),
    .dma_rdata_o  (dma_rdata),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd),
    .perf_stall_o (perf_stall),
    .perf_dma_o   (perf_dma)
  );

  // Memory model: 0x10 holds DEADBEEF and other unwritten words read A50000xx.
  logic [31:0]  wmem [256];
  logic [255:0] wvalid = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      wmem[mem_addr[7:0]]   <= mem_wd;
      wvalid[mem_addr[7:0]] <= 1'b1;
    end
  end
  assign mem_rd = wvalid[mem_addr[7:0]] ? wmem[mem_addr[7:0]] :
                  (mem_addr[7:0] == 8'h10) ? 32'hDEAD_BEEF : {24'hA5_0000, mem_addr[7:0]};

  task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dl, input bit dw, input logic [31:0] da,
                       input logic [31:0] dd);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dma_req = dr; dma_lock = dl; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic test_reset();
    bit ed;
    logic [31:0] e;
    logic [64:0] xb;
    drive(1, 1, 32'h10, 32'h1234, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_we} !== 5'b0) begin
      failed++;
      $display("FAIL reset_ctl: got gnt=%b%b rv=%b%b we=%b, want all 0",
               core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_we);
    end
    tests++;
    if ({mem_addr, mem_wd, core_rdata, dma_rdata, perf_stall, perf_dma} !== '0) begin
      failed++;
      $display("FAIL reset_data: got addr=%h wd=%h crd=%h drd=%h ps=%0d pd=%0d, want all 0",
               mem_addr, mem_wd, core_rdata, dma_rdata, perf_stall, perf_dma);
    end
    @(posedge clk); @(posedge clk); #1;
    tests++;
    if ({core_gnt, mem_we} !== 2'b0) begin
      failed++;
      $display("FAIL reset_hold: got core_gnt=%b mem_we=%b, want 0 0", core_gnt, mem_we);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    // DMA read traffic, then reset lands in the middle of a granted read.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0, 32'h30 + 32'(4 * i), 0);
      ed = 1'b1;
      @(negedge clk);
      if (dma_sb.size() != 0 || dma_rvalid) begin
        tests++;
        if (dma_sb.size() == 0) begin
          failed++; $display("FAIL reset_sb dma_rvalid: got 1, want 0");
        end else begin
          e = dma_sb.pop_front();
          if (dma_rvalid !== 1'b1 || dma_rdata !== e) begin
            failed++;
            $display("FAIL reset_sb dma_rd[%0d]: got v=%b d=%h, want v=1 d=%h",
                     i, dma_rvalid, dma_rdata, e);
          end
        end
      end
      tests++;
      if ({core_gnt, dma_gnt} !== {1'b0, ed}) begin
        failed++; $display("FAIL reset_gnt[%0d]: got %b%b, want 0%b", i, core_gnt, dma_gnt, ed);
      end
      xb = {1'b0, dma_addr, 32'h0};
      tests++;
      if ({mem_we, mem_addr, mem_wd} !== xb) begin
        failed++; $display("FAIL reset_bus[%0d]: got %h, want %h", i, {mem_we, mem_addr, mem_wd}, xb);
      end
      if (i < 2) begin
        dma_sb.push_back({24'hA5_0000, 8'h30 + 8'(4 * i)});
        @(posedge clk); #1;
      end
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({core_gnt, dma_gnt, dma_rvalid, mem_we} !== 4'b0) begin
      failed++;
      $display("FAIL reset_mid: got gnt=%b%b dma_rv=%b we=%b, want 0", core_gnt, dma_gnt,
               dma_rvalid, mem_we);
    end
    @(posedge clk); #1;
    tests++;
    if ({dma_rvalid, dma_rdata} !== 33'b0) begin
      failed++;
      $display("FAIL reset_drop: got dma_rv=%b d=%h, want 0 0", dma_rvalid, dma_rdata);
    end
    // Release with both requesting: the state is idle, so the core must win at once.
    drive(1, 0, 32'h10, 0, 1, 0, 0, 32'h30, 0);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({core_gnt, dma_gnt, core_stall} !== 3'b100) begin
      failed++;
      $display("FAIL reset_release: got gnt=%b%b stall=%b, want 10 0", core_gnt, dma_gnt, core_stall);
    end
    core_sb.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1;
  endtask

  task automatic test_core_only();
    bit ec;
    logic [31:0] e;
    logic [64:0] xb;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0); ec = 1'b1;
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); ec = 1'b0;
      end
      @(negedge clk);
      if (core_sb.size() != 0 || core_rvalid) begin
        tests++;
        if (core_sb.size() == 0) begin
          failed++; $display("FAIL core_only core_rvalid[%0d]: got 1, want 0", i);
        end else begin
          e = core_sb.pop_front();
          if (core_rvalid !== 1'b1 || core_rdata !== e) begin
            failed++;
            $display("FAIL core_only core_rd[%0d]: got v=%b d=%h, want v=1 d=%h",
                     i, core_rvalid, core_rdata, e);
          end
        end
      end
      tests++;
      if ({core_gnt, dma_gnt, core_stall} !== {ec, 1'b0, 1'b0}) begin
        failed++;
        $display("FAIL core_only gnt[%0d]: got %b%b stall=%b, want %b0 0", i, core_gnt, dma_gnt,
                 core_stall, ec);
      end
      xb = ec ? {1'b0, 32'h10, 32'h0} : 65'h0;
      tests++;
      if ({mem_we, mem_addr, mem_wd} !== xb) begin
        failed++; $display("FAIL core_only bus[%0d]: got %h, want %h", i, {mem_we, mem_addr, mem_wd}, xb);
      end
      if (i == 3) begin
        tests++;
        if ({core_rvalid, core_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
          failed++;
          $display("FAIL core_only hold: got v=%b d=%h, want v=0 d=deadbeef", core_rvalid, core_rdata);
        end
      end
      if (ec) core_sb.push_back(32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    bit ec, ed;
    logic [31:0] e;
    logic [64:0] xb;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); ec = 1'b0; ed = 1'b0;
      end else begin
        drive(1, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0); ec = (i % 2 == 1); ed = (i % 2 == 0);
      end
      @(negedge clk);
      if (core_sb.size() != 0 || core_rvalid) begin
        tests++;
        if (core_sb.size() == 0) begin
          failed++; $display("FAIL contention core_rvalid[%0d]: got 1, want 0", i);
        end else begin
          e = core_sb.pop_front();
          if (core_rvalid !== 1'b1 || core_rdata !== e) begin
            failed++;
            $display("FAIL contention core_rd[%0d]: got v=%b d=%h, want v=1 d=%h",
                     i, core_rvalid, core_rdata, e);
          end
        end
      end
      if (dma_sb.size() != 0 || dma_rvalid) begin
        tests++;
        if (dma_sb.size() == 0) begin
          failed++; $display("FAIL contention dma_rvalid[%0d]: got 1, want 0", i);
        end else begin
          e = dma_sb.pop_front();
          if (dma_rvalid !== 1'b1 || dma_rdata !== e) begin
            failed++;
            $display("FAIL contention dma_rd[%0d]: got v=%b d=%h, want v=1 d=%h",
                     i, dma_rvalid, dma_rdata, e);
          end
        end
      end
      tests++;
      if ({core_gnt, dma_gnt, core_stall} !== {ec, ed, core_req & ~ec}) begin
        failed++;
        $display("FAIL contention gnt[%0d]: got %b%b stall=%b, want %b%b stall=%b", i, core_gnt,
                 dma_gnt, core_stall, ec, ed, core_req & ~ec);
      end
      xb = ec ? {1'b0, 32'h20, 32'h0} : ed ? {1'b0, 32'h24, 32'h0} : 65'h0;
      tests++;
      if ({mem_we, mem_addr, mem_wd} !== xb) begin
        failed++;
        $display("FAIL contention bus[%0d]: got %h, want %h", i, {mem_we, mem_addr, mem_wd}, xb);
      end
      if (ec) core_sb.push_back(32'hA500_0020);
      if (ed) dma_sb.push_back(32'hA500_0024);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst();
    bit ec, ed;
    logic [31:0] e;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); ec = 1'b0; ed = 1'b0;
      end else if (i == 1) begin
        drive(0, 0, 0, 0, 1, 1, 0, 32'h30, 0); ec = 1'b0; ed = 1'b1;
      end else begin
        // Four DMA grants, then the core; the window restarts after the core grant.
        drive(1, 0, 32'h34, 0, 1, 1, 0, 32'h30, 0); ec = (i == 6 || i == 11); ed = ~ec;
      end
      @(negedge clk);
      if (core_sb.size() != 0 || core_rvalid) begin
        tests++;
        if (core_sb.size() == 0) begin
          failed++; $display("FAIL burst core_rvalid[%0d]: got 1, want 0", i);
        end else begin
          e = core_sb.pop_front();
          if (core_rvalid !== 1'b1 || core_rdata !== e) begin
            failed++;
            $display("FAIL burst core_rd[%0d]: got v=%b d=%h, want v=1 d=%h",
                     i, core_rvalid, core_rdata, e);
          end
        end
      end
      if (dma_sb.size() != 0 || dma_rvalid) begin
        tests++;
        if (dma_sb.size() == 0) begin
          failed++; $display("FAIL burst dma_rvalid[%0d]: got 1, want 0", i);
        end else begin
          e = dma_sb.pop_front();
          if (dma_rvalid !== 1'b1 || dma_rdata !== e) begin
            failed++;
            $display("FAIL burst dma_rd[%0d]: got v=%b d=%h, want v=1 d=%h",
                     i, dma_rvalid, dma_rdata, e);
          end
        end
      end
      tests++;
      if ({core_gnt, dma_gnt, core_stall} !== {ec, ed, core_req & ~ec}) begin
        failed++;
        $display("FAIL burst gnt[%0d]: got %b%b stall=%b, want %b%b stall=%b", i, core_gnt,
                 dma_gnt, core_stall, ec, ed, core_req & ~ec);
      end
      if (ec) core_sb.push_back(32'hA500_0034);
      if (ed) dma_sb.push_back(32'hA500_0030);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dma_write_core_read();
    bit ec, ed;
    logic [31:0] e;
    logic [64:0] xb;
    for (int i = 0; i < 4; i++) begin
      ec = 1'b0; ed = 1'b0; xb = 65'h0;
      if (i == 1) begin
        drive(0, 0, 0, 0, 1, 0, 1, 32'h40, 32'h55AA_55AA); ed = 1'b1;
        xb = {1'b1, 32'h40, 32'h55AA_55AA};
      end else if (i == 2) begin
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0); ec = 1'b1; xb = {1'b0, 32'h40, 32'h0};
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      if (core_sb.size() != 0 || core_rvalid) begin
        tests++;
        if (core_sb.size() == 0) begin
          failed++; $display("FAIL wr_rd core_rvalid[%0d]: got 1, want 0", i);
        end else begin
          e = core_sb.pop_front();
          if (core_rvalid !== 1'b1 || core_rdata !== e) begin
            failed++;
            $display("FAIL wr_rd core_rd[%0d]: got v=%b d=%h, want v=1 d=%h",
                     i, core_rvalid, core_rdata, e);
          end
        end
      end
      if (dma_sb.size() != 0 || dma_rvalid) begin
        tests++;
        if (dma_sb.size() == 0) begin
          failed++; $display("FAIL wr_rd dma_rvalid[%0d]: got 1, want 0", i);
        end else begin
          e = dma_sb.pop_front();
          if (dma_rvalid !== 1'b1 || dma_rdata !== e) begin
            failed++;
            $display("FAIL wr_rd dma_rd[%0d]: got v=%b d=%h, want v=1 d=%h", i, dma_rvalid, dma_rdata, e);
          end
        end
      end
      tests++;
      if ({core_gnt, dma_gnt} !== {ec, ed}) begin
        failed++; $display("FAIL wr_rd gnt[%0d]: got %b%b, want %b%b", i, core_gnt, dma_gnt, ec, ed);
      end
      tests++;
      if ({mem_we, mem_addr, mem_wd} !== xb) begin
        failed++; $display("FAIL wr_rd bus[%0d]: got %h, want %h", i, {mem_we, mem_addr, mem_wd}, xb);
      end
      if (ec) core_sb.push_back(32'h55AA_55AA);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_perf();
    bit ec, ed;
    logic [31:0] e;
    logic [31:0] xs, xd;
`ifdef DATA_MEM_ARB_PERF_EN
    xs = 32'd3; xd = 32'd5;
`else
    xs = 32'd0; xd = 32'd0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ec = 1'b0; ed = 1'b1;
      if (i < 2) begin
        drive(0, 0, 0, 0, 1, 0, 0, 32'h30, 0);
      end else if (i < 5) begin
        drive(1, 0, 32'h34, 0, 1, 1, 0, 32'h30, 0);
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); ed = 1'b0;
      end
      @(negedge clk);
      if (dma_sb.size() != 0 || dma_rvalid) begin
        tests++;
        if (dma_sb.size() == 0) begin
          failed++; $display("FAIL perf dma_rvalid[%0d]: got 1, want 0", i);
        end else begin
          e = dma_sb.pop_front();
          if (dma_rvalid !== 1'b1 || dma_rdata !== e) begin
            failed++;
            $display("FAIL perf dma_rd[%0d]: got v=%b d=%h, want v=1 d=%h", i, dma_rvalid, dma_rdata, e);
          end
        end
      end
      tests++;
      if ({core_gnt, dma_gnt, core_stall} !== {ec, ed, core_req & ~ec}) begin
        failed++;
        $display("FAIL perf gnt[%0d]: got %b%b stall=%b, want %b%b stall=%b", i, core_gnt, dma_gnt,
                 core_stall, ec, ed, core_req & ~ec);
      end
      if (i == 5) begin
        tests++;
        if (perf_stall !== xs || perf_dma !== xd) begin
          failed++;
          $display("FAIL perf counters: got stall=%0d dma=%0d, want stall=%0d dma=%0d",
                   perf_stall, perf_dma, xs, xd);
        end
      end
      if (ed) dma_sb.push_back(32'hA500_0030);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_core_only();
    test_contention();
    test_burst();
    test_dma_write_core_read();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
